if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage ARM core: owns the program counter, issues one instruction-memory request at a time, and delivers fetched instructions through the IF/ID pipeline register into the decode stage, where the control unit consumes them. It handles branch redirection from EXE, including discarding an in-flight fetch, and hazard freeze from the hazard unit.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard stall; hold PC and IF/ID register
- branch_taken  in  1  redirect request from EXE
- branch_addr  in  ADDR_W  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  fetch address (= PC)
- imem_rsp_valid  in  1  instruction returned (one-cycle pulse)
- imem_rsp_data  in  INSTR_W  returned instruction
- pc_out  out  ADDR_W  IF/ID: address of instruction + 4
- instr_out  out  INSTR_W  IF/ID: instruction
- valid_out  out  1  IF/ID: entry holds a real instruction (0 = bubble/NOP)

## Operation
- At most one outstanding request. FSM states: REQ, WAIT, HOLD, DROP.
- REQ: imem_req_valid=1, imem_req_addr=pc. Handshake (valid&ready) -> WAIT.
- WAIT: on imem_rsp_valid with freeze=0: instr_out<=data, pc_out<=pc+4, valid_out<=1, pc<=pc+4 -> REQ. With freeze=1: data to hold buffer -> HOLD.
- HOLD: imem_req_valid=0; when freeze=0 load IF/ID from buffer, pc<=pc+4 -> REQ.
- DROP: wait for the stale response, discard it -> REQ.
- IF/ID update rule: freeze=1 holds pc_out/instr_out/valid_out; freeze=0 with no instruction to load writes valid_out<=0 (bubble).
- branch_taken has priority over freeze and over all loads: pc<=branch_addr, valid_out<=0, hold buffer discarded. Next state: REQ->REQ (address changes while unaccepted is permitted; memory samples only on handshake), REQ with handshake in same cycle->DROP, WAIT without rsp->DROP, WAIT with rsp in same cycle->REQ (response discarded), HOLD->REQ, DROP->DROP (pc updated, stale response still pending).
- PC arithmetic: ADDR_W bits, +4 wraps modulo 2^ADDR_W; branch_addr used unaligned as given.

## Timing
- Reset (rst=1 at edge): pc=RESET_PC, state=REQ, pc_out=0, instr_out=0, valid_out=0, imem_req_valid=0 during reset cycle, 1 from the first cycle after release.
- imem_req_* combinational from state/pc; no combinational path from imem_rsp_* to imem_req_*.
- Zero-wait memory (ready=1, rsp next cycle): one instruction per 2 cycles; IF/ID valid the edge after rsp_valid.
- Branch: redirected request issued the cycle after branch_taken (REQ/HOLD origin) or the cycle after the stale response (DROP).
- rst mid-operation overrides everything; an outstanding response arriving after reset is not tracked (memory is reset alongside).

## Configuration
- IF_PERF_CNT_EN defined: adds outputs fetch_count (32) and stall_count (32); fetch_count increments on every IF/ID load with valid_out<=1, stall_count on every cycle with freeze=1; both cleared by rst, wrap at 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared package arm_pkg: fetch-state enum (REQ/WAIT/HOLD/DROP), RESET_PC default, INSTR_W/ADDR_W constants.
- One sub-module if_id_reg: IF/ID register with load, freeze, flush inputs; FSM and PC live in if_stage.

## Test plan
- Reset, zero-wait memory returning 32'hE3A0_1005 at 0: first request addr 0, IF/ID pc_out=4, instr_out=32'hE3A0_1005, valid_out=1; next request addr 4.
- freeze=1 for 3 cycles while response arrives at addr 8: HOLD, no new request, IF/ID unchanged; after release pc_out=12, pc=12.
- branch_taken to 32'h100 while in WAIT: stale response discarded, valid_out=0, next request addr 32'h100.
- branch_taken coincident with rsp_valid in WAIT: response dropped, request to branch_addr the next cycle, no DROP state.
- imem_req_ready held 0 for 4 cycles with branch mid-wait: imem_req_addr switches to branch_addr, handshake fetches branch target.
- pc=32'hFFFF_FFFC fetch: pc_out=0, next request addr 0; with IF_PERF_CNT_EN, fetch_count and stall_count match counted loads/freeze cycles.

Source files
------------

// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the five-stage ARM core front end:
//   - ADDR_W / INSTR_W : PC and instruction widths
//   - RESET_PC         : PC value after reset
//   - fetch_state_e    : instruction-fetch FSM states
//   - pc_inc()         : sequential PC increment (+4, wraps modulo 2^ADDR_W)
// -----------------------------------------------------------------------------
package arm_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // request presented to instruction memory
        ST_WAIT = 2'd1,   // request accepted, waiting for the response
        ST_HOLD = 2'd2,   // response captured during freeze, waiting to load IF/ID
        ST_DROP = 2'd3    // redirected; waiting to discard a stale response
    } fetch_state_e;

    // Next sequential fetch address; the adder wraps naturally at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.
// Priority (highest first): rst, flush, freeze, load, bubble.
//   clk        in   clock
//   rst        in   synchronous active-high reset (clears all fields)
//   i_flush    in   branch redirect: insert bubble (valid <= 0)
//   i_freeze   in   hold all fields
//   i_load     in   capture i_pc / i_instr and mark valid
//   i_pc       in   address of instruction + 4
//   i_instr    in   instruction
//   o_pc       out  registered pc
//   o_instr    out  registered instruction
//   o_valid    out  entry holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_freeze,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_valid
);

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;

    // IF/ID register update; pc/instr keep their last value when a bubble is
    // written so only valid changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_freeze) begin
            r_valid <= r_valid;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request outstanding and feeds the IF/ID register.
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   freeze          in   hazard stall: hold PC and IF/ID
//   branch_taken    in   redirect from EXE (priority over freeze and loads)
//   branch_addr     in   redirect target (used unaligned as given)
//   imem_req_valid  out  fetch request valid (combinational from state)
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  fetch address (= pc)
//   imem_rsp_valid  in   instruction returned (one-cycle pulse)
//   imem_rsp_data   in   returned instruction
//   pc_out          out  IF/ID: address of instruction + 4
//   instr_out       out  IF/ID: instruction
//   valid_out       out  IF/ID: real instruction (0 = bubble)
// Optional feature macro IF_PERF_CNT_EN adds:
//   fetch_count     out  number of IF/ID loads with valid
//   stall_count     out  number of cycles with freeze=1
// -----------------------------------------------------------------------------
module if_stage
    import arm_pkg::*;
#(
    parameter int                ADDR_W   = arm_pkg::ADDR_W,
    parameter int                INSTR_W  = arm_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = arm_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count,
`endif
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out
);

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_hold_data;

    fetch_state_e       w_next_state;
    logic [ADDR_W-1:0]  w_next_pc;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_load;
    logic [INSTR_W-1:0] w_load_instr;
    logic               w_buf_we;
    logic               w_handshake;

    assign w_pc_inc    = pc_inc(r_pc);
    assign w_handshake = imem_req_valid & imem_req_ready;

    // Request side depends only on state, pc and rst; rst masks the request
    // during the reset cycle itself.
    assign imem_req_valid = (r_state == ST_REQ) && !rst;
    assign imem_req_addr  = r_pc;

    // Next-state, next-PC and IF/ID load decisions.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_load       = 1'b0;
        w_load_instr = imem_rsp_data;
        w_buf_we     = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (branch_taken) begin
                    // An accepted request this cycle leaves a stale response behind.
                    w_next_pc    = branch_addr;
                    w_next_state = w_handshake ? ST_DROP : ST_REQ;
                end else if (w_handshake) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (branch_taken) begin
                    w_next_pc    = branch_addr;
                    w_next_state = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid && !freeze) begin
                    w_load       = 1'b1;
                    w_next_pc    = w_pc_inc;
                    w_next_state = ST_REQ;
                end else if (imem_rsp_valid) begin
                    w_buf_we     = 1'b1;
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    w_next_pc    = branch_addr;
                    w_next_state = ST_REQ;
                end else if (!freeze) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold_data;
                    w_next_pc    = w_pc_inc;
                    w_next_state = ST_REQ;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_DROP: begin
                // The stale response ends the drop even if a new redirect
                // arrives with it; nothing else is outstanding afterwards.
                if (branch_taken) begin
                    w_next_pc = branch_addr;
                end else begin
                    w_next_pc = r_pc;
                end
                w_next_state = imem_rsp_valid ? ST_REQ : ST_DROP;
            end
            default: begin
                w_next_state = ST_REQ;
            end
        endcase
    end

    // FSM, PC and hold-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_hold_data <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_buf_we) begin
                r_hold_data <= imem_rsp_data;
            end else begin
                r_hold_data <= r_hold_data;
            end
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (branch_taken),
        .i_freeze (freeze),
        .i_load   (w_load),
        .i_pc     (w_pc_inc),
        .i_instr  (w_load_instr),
        .o_pc     (pc_out),
        .o_instr  (instr_out),
        .o_valid  (valid_out)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Performance counters; w_load is only raised for loads that really
    // reach IF/ID (no redirect, no freeze).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            r_fetch_count <= w_load ? (r_fetch_count + 32'd1) : r_fetch_count;
            r_stall_count <= freeze ? (r_stall_count + 32'd1) : r_stall_count;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed, table-driven bench for if_stage. Each table row is one clock
// cycle: inputs are driven after the falling edge, the request outputs are
// compared before the rising edge and the IF/ID outputs just after it.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
`ifdef IF_PERF_CNT_EN
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
`endif
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .valid_out      (valid_out)
    );

    typedef struct {
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ereqv;
        logic [31:0] eaddr;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        evalid;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic frz, input logic br, input logic [31:0] baddr,
                                input logic rdy, input logic rv, input logic [31:0] rdata,
                                input logic ereqv, input logic [31:0] eaddr,
                                input logic [31:0] epc, input logic [31:0] einstr,
                                input logic evalid);
        vec_t v;
        v.frz = frz; v.br = br; v.baddr = baddr; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.ereqv = ereqv; v.eaddr = eaddr; v.epc = epc; v.einstr = einstr; v.evalid = evalid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_addr    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    initial begin
        //            frz   br    baddr          rdy   rv    rdata          reqv  addr           pc_out         instr          valid
        // zero-wait fetch from reset address
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hE3A0_1005, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'hE3A0_1005, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 32'h0000_0004, 32'hE3A0_1005, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0000_0004, 32'h0000_0008, 32'h1111_1111, 1'b1);
        // freeze for 3 cycles while the response for addr 8 arrives
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 32'h0000_0008, 32'h1111_1111, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2222_2222, 1'b0, 32'h0000_0008, 32'h0000_0008, 32'h1111_1111, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 32'h0000_0008, 32'h1111_1111, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 32'h0000_0008, 32'h1111_1111, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 32'h0000_000C, 32'h2222_2222, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_000C, 32'h2222_2222, 1'b0);
        // branch in WAIT without response -> DROP, stale response discarded
        vecs[10] = mk(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 32'h0000_000C, 32'h2222_2222, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 32'h0000_000C, 32'h2222_2222, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 32'h0000_000C, 32'h2222_2222, 1'b0);
        // branch coincident with response in WAIT -> straight to REQ
        vecs[13] = mk(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 32'h0000_0100, 32'h0000_000C, 32'h2222_2222, 1'b0);
        // ready low for 4 cycles with a branch in the middle
        vecs[14] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 32'h0000_000C, 32'h2222_2222, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 32'h0000_000C, 32'h2222_2222, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 32'h0000_000C, 32'h2222_2222, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0300, 32'h0000_000C, 32'h2222_2222, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0300, 32'h0000_000C, 32'h2222_2222, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4444_4444, 1'b0, 32'h0000_0300, 32'h0000_0304, 32'h4444_4444, 1'b1);
        // PC wrap at the top of the address space
        vecs[20] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0304, 32'h0000_0304, 32'h4444_4444, 1'b0);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_0304, 32'h4444_4444, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h5555_5555, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h5555_5555, 1'b1);
        vecs[23] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0000, 32'h5555_5555, 1'b0);
        // branch in REQ with same-cycle handshake -> DROP
        vecs[24] = mk(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0000, 32'h5555_5555, 1'b0);
        vecs[25] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0040, 32'h0000_0000, 32'h5555_5555, 1'b0);
        vecs[26] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h6666_6666, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h5555_5555, 1'b0);
        vecs[27] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0040, 32'h0000_0000, 32'h5555_5555, 1'b0);
        vecs[28] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h7777_7777, 1'b0, 32'h0000_0040, 32'h0000_0044, 32'h7777_7777, 1'b1);

        // Reset: two cycles, request masked while rst is high.
        drive_idle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        check("reset_pc_out",    pc_out,    32'h0);
        check("reset_instr_out", instr_out, 32'h0);
        check("reset_valid_out", {31'd0, valid_out}, 32'd0);

        // Table-driven cycle vectors.
        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            freeze         = vecs[i].frz;
            branch_taken   = vecs[i].br;
            branch_addr    = vecs[i].baddr;
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rv;
            imem_rsp_data  = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].ereqv});
            check($sformatf("v%0d_req_addr", i),  imem_req_addr, vecs[i].eaddr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc_out", i),    pc_out,    vecs[i].epc);
            check($sformatf("v%0d_instr_out", i), instr_out, vecs[i].einstr);
            check($sformatf("v%0d_valid_out", i), {31'd0, valid_out}, {31'd0, vecs[i].evalid});
        end

`ifdef IF_PERF_CNT_EN
        // Loads with valid: rows 1,3,8,19,22,28; freeze cycles: rows 5,6,7.
        check("fetch_count", fetch_count, 32'd6);
        check("stall_count", stall_count, 32'd3);
`endif

        // Mid-operation reset while a request is outstanding (state WAIT).
        @(negedge clk);
        drive_idle();
        imem_req_ready = 1'b1;
        #1;
        check("mid_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("mid_req_addr",  imem_req_addr, 32'h0000_0044);
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("post_rst_req_addr",  imem_req_addr, 32'h0);
        check("post_rst_pc_out",    pc_out,    32'h0);
        check("post_rst_instr_out", instr_out, 32'h0);
        check("post_rst_valid_out", {31'd0, valid_out}, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("post_rst_fetch_count", fetch_count, 32'd0);
        check("post_rst_stall_count", stall_count, 32'd0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
